// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction fetch slice.
package mips_fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // Byte address to word index shift for the instruction memory.
    localparam int WORD_SHIFT = 2;

    // Value shown on inst_data while nothing has been fetched yet.
    localparam logic [31:0] INST_NOP = 32'h0;

    // Entries in the skid buffer between memory and decode.
    localparam int BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, execute and decode.
interface instruction_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] fault_pc;

    // Fetch unit side.
    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        output fault,
        output fault_pc
    );

    // Environment side: memory, execute and decode.
    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/instruction_fetch_unit_skid_fifo.sv
// Two-entry {pc, inst} skid buffer; flush wins over push and pop.
module fetch_skid_fifo
    import mips_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst,
    output logic [1:0]  count
);

    fetch_entry_t entries [BUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    assign head_pc   = entries[rd_ptr].pc;
    assign head_inst = entries[rd_ptr].inst;

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see the pre-edge values.
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            // NOTE: storage is reset because its head is a visible output (inst_data/inst_pc = 0).
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entries[i] <= '{pc: 32'h0, inst: INST_NOP};
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= rd_ptr;
        end else begin
            if (push) begin
                entries[wr_ptr] <= '{pc: push_pc, inst: push_inst};
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC sequencing, credit-based issue, epoch-tagged capture,
// redirect handling and a sticky misaligned-target fault.
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         req_epoch;
    logic         epoch;
    logic         inflight;
    logic [31:0]  fault_pc_q;

    logic [1:0]   count;
    logic [2:0]   credit_use;
    logic         pop;
    logic         push;
    logic         issue;
    logic         redirect_hit;
    logic         misaligned;

    assign redirect_hit   = bus.redirect_valid && (state == RUN);
    assign misaligned     = (bus.redirect_pc[1:0] != 2'b00);

    assign bus.imem_addr  = pc >> WORD_SHIFT;
    assign bus.inst_valid = (count != 2'd0) && !bus.redirect_valid && (state == RUN);
    assign bus.fault      = (state == FAULT);
    assign bus.fault_pc   = fault_pc_q;

    assign pop        = bus.inst_valid && bus.inst_ready;
    // Slots already claimed once this cycle's pop frees one.
    assign credit_use = 3'(count) + 3'(inflight) - 3'(pop);

    // Issue and capture decisions; both are blocked by a redirect or a fault.
    always_comb begin
        // NOTE: defaults first so no path leaves issue/push unassigned (no latch).
        issue = 1'b0;
        push  = 1'b0;
        if ((state == RUN) && !bus.redirect_valid) begin
            issue = (credit_use < 3'(BUF_DEPTH));
            push  = inflight && (req_epoch == epoch);
        end
    end

    fetch_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_hit),
        .push_pc   (req_pc),
        .push_inst (bus.imem_rdata),
        .head_pc   (bus.inst_pc),
        .head_inst (bus.inst_data),
        .count     (count)
    );

    // PC, in-flight tracking, epoch and fault state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= RESET_PC;
            req_pc     <= 32'h0;
            req_epoch  <= 1'b0;
            epoch      <= 1'b0;
            inflight   <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc    <= pc;
                req_epoch <= epoch;
                pc        <= pc + 32'd4;
            end
            if (redirect_hit) begin
                if (misaligned) begin
                    state      <= FAULT;
                    fault_pc_q <= bus.redirect_pc;
                end else begin
                    pc    <= bus.redirect_pc;
                    epoch <= ~epoch;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed timing scenarios
// plus a randomized ready/redirect phase checked against a stream model.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus0();
    instruction_fetch_unit_if bus1();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int total = 0;
    int bad   = 0;

    // Memory contents: word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] word_idx);
        return 32'h1000_0000 + word_idx;
    endfunction

    // Synchronous memories: data for the address seen at an edge appears after it.
    always @(posedge clk) begin
        bus0.imem_rdata <= mem_word(bus0.imem_addr);
        bus1.imem_rdata <= mem_word(bus1.imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Model of the delivered stream: next byte address decode should see.
    logic [31:0] exp_pc;

    // Expect an instruction at the head; consume it if ready is driven high.
    task automatic expect_stream(input string tag);
        check({tag, "_valid"}, 32'(bus0.inst_valid), 32'd1);
        check({tag, "_pc"}, bus0.inst_pc, exp_pc);
        check({tag, "_data"}, bus0.inst_data, mem_word(exp_pc >> 2));
        if (bus0.inst_ready) exp_pc = exp_pc + 32'd4;
    endtask

    initial begin
        logic [31:0] tgt;
        logic [31:0] hold_pc;
        logic [31:0] frozen_addr;
        bit          redir;
        bit          hold;
        int          since_redir;
        int          transfers;

        rst                 = 1'b1;
        bus0.inst_ready     = 1'b1;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc    = 32'h0;
        bus1.inst_ready     = 1'b1;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = 32'h0;

        // Reset state.
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_valid", 32'(bus0.inst_valid), 32'd0);
        check("rst_imem_addr", bus0.imem_addr, 32'h0);
        check("rst_inst_data", bus0.inst_data, 32'h0);
        check("rst_inst_pc", bus0.inst_pc, 32'h0);
        check("rst_fault", 32'(bus0.fault), 32'd0);
        check("rst_fault_pc", bus0.fault_pc, 32'h0);
        check("rst_imem_addr_hi", bus1.imem_addr, 32'h3FFF_FFFE);
        next_cycle();
        rst = 1'b0;

        // First fetch: valid only in the third cycle after reset.
        @(negedge clk);
        check("c1_valid", 32'(bus0.inst_valid), 32'd0);
        check("c1_imem_addr", bus0.imem_addr, 32'h0);
        next_cycle();
        @(negedge clk);
        check("c2_valid", 32'(bus0.inst_valid), 32'd0);
        check("c2_imem_addr", bus0.imem_addr, 32'h1);
        next_cycle();

        // Steady stream, one per cycle; the high-RESET_PC unit wraps past 2^32.
        exp_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            expect_stream("stream");
            if (i < 3) begin
                tgt = 32'hFFFF_FFF8 + 32'(i * 4);
                check("wrap_valid", 32'(bus1.inst_valid), 32'd1);
                check("wrap_pc", bus1.inst_pc, tgt);
                check("wrap_data", bus1.inst_data, mem_word(tgt >> 2));
            end
            next_cycle();
        end

        // Back-pressure for 5 cycles: head held, fetch address frozen.
        bus0.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            expect_stream("stall");
            check("stall_imem_addr", bus0.imem_addr, (exp_pc + 32'd8) >> 2);
            next_cycle();
        end
        bus0.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            expect_stream("release");
            next_cycle();
        end

        // Redirect in a full-rate stream (one read in flight).
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 32'h0000_0040;
        @(negedge clk);
        check("redir1_valid", 32'(bus0.inst_valid), 32'd0);
        next_cycle();
        bus0.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("redir1_bubble", 32'(bus0.inst_valid), 32'd0);
            if (i == 0) check("redir1_imem_addr", bus0.imem_addr, 32'h10);
            next_cycle();
        end
        exp_pc = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_stream("redir1");
            next_cycle();
        end

        // Redirect while the buffer is full under back-pressure.
        bus0.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prefill_valid", 32'(bus0.inst_valid), 32'd1);
            next_cycle();
        end
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 32'h0000_0080;
        @(negedge clk);
        check("redir2_valid", 32'(bus0.inst_valid), 32'd0);
        next_cycle();
        bus0.redirect_valid = 1'b0;
        bus0.inst_ready     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("redir2_bubble", 32'(bus0.inst_valid), 32'd0);
            next_cycle();
        end
        exp_pc = 32'h0000_0080;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_stream("redir2");
            next_cycle();
        end

        // Randomized ready and aligned redirects against the stream model.
        since_redir = 10;
        hold        = 1'b0;
        hold_pc     = 32'h0;
        transfers   = 0;
        for (int i = 0; i < 400; i++) begin
            redir = ($urandom_range(0, 31) == 0);
            tgt   = $urandom();
            tgt[1:0] = 2'b00;
            bus0.inst_ready     = ($urandom_range(0, 3) != 0);
            bus0.redirect_valid = redir;
            bus0.redirect_pc    = tgt;
            if (since_redir < 10) since_redir++;
            @(negedge clk);
            if (redir) begin
                check("rand_redir_valid", 32'(bus0.inst_valid), 32'd0);
            end else if (since_redir < 3) begin
                check("rand_bubble", 32'(bus0.inst_valid), 32'd0);
            end else if (since_redir == 3) begin
                check("rand_refill", 32'(bus0.inst_valid), 32'd1);
            end
            if (hold && !redir) begin
                check("rand_hold_valid", 32'(bus0.inst_valid), 32'd1);
                check("rand_hold_pc", bus0.inst_pc, hold_pc);
            end
            if (bus0.inst_valid && !redir) begin
                check("rand_pc", bus0.inst_pc, exp_pc);
                check("rand_data", bus0.inst_data, mem_word(exp_pc >> 2));
            end
            if (redir) begin
                exp_pc      = tgt;
                since_redir = 0;
                hold        = 1'b0;
            end else begin
                hold    = bus0.inst_valid && !bus0.inst_ready;
                hold_pc = exp_pc;
                if (bus0.inst_valid && bus0.inst_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    transfers++;
                end
            end
            next_cycle();
        end
        check("rand_progress", 32'(transfers > 50), 32'd1);

        // Reset while a read is in flight: stale data must never appear.
        bus0.redirect_valid = 1'b0;
        bus0.inst_ready     = 1'b1;
        repeat (4) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rstmid_bubble", 32'(bus0.inst_valid), 32'd0);
            next_cycle();
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_stream("rstmid");
            next_cycle();
        end

        // Misaligned redirect: sticky fault, no more fetch, later redirects ignored.
        frozen_addr         = (exp_pc + 32'd8) >> 2;
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 32'h0000_0042;
        @(negedge clk);
        check("fault_redir_valid", 32'(bus0.inst_valid), 32'd0);
        check("fault_not_yet", 32'(bus0.fault), 32'd0);
        next_cycle();
        bus0.redirect_pc = 32'h0000_0010;
        @(negedge clk);
        check("fault_flag", 32'(bus0.fault), 32'd1);
        check("fault_pc", bus0.fault_pc, 32'h0000_0042);
        check("fault_valid", 32'(bus0.inst_valid), 32'd0);
        next_cycle();
        bus0.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fault_hold_flag", 32'(bus0.fault), 32'd1);
            check("fault_hold_pc", bus0.fault_pc, 32'h0000_0042);
            check("fault_hold_valid", 32'(bus0.inst_valid), 32'd0);
            check("fault_hold_addr", bus0.imem_addr, frozen_addr);
            next_cycle();
        end

        // Only reset clears the fault.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("unfault_flag", 32'(bus0.fault), 32'd0);
        check("unfault_pc", bus0.fault_pc, 32'h0);
        next_cycle();
        next_cycle();
        exp_pc = 32'h0;
        @(negedge clk);
        expect_stream("unfault");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequences the synchronous, word-indexed instruction memory for the MIPS core: owns the program counter, issues one read per cycle when there is room downstream, and absorbs the memory's one-cycle read latency in a 2-entry skid buffer. Fetched words go to decode through a valid/ready handshake. Branch/jump redirects from execute flush the buffer and any in-flight read. A misaligned redirect target stops fetch and raises a sticky fault.

## Interface
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (must be word-aligned)
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  word index to instruction memory = {2'b00, pc[31:2]}
- imem_rdata  in  32  memory data, valid the cycle after imem_addr was presented
- redirect_valid  in  1  execute requests a PC change this cycle
- redirect_pc  in  32  byte address of the redirect target
- inst_valid  out  1  inst_data/inst_pc hold a fetched instruction
- inst_ready  in  1  decode accepts; transfer when inst_valid && inst_ready
- inst_data  out  32  instruction word at buffer head
- inst_pc  out  32  byte address of inst_data
- fault  out  1  sticky: a misaligned redirect was received
- fault_pc  out  32  offending redirect_pc, captured once

## Operation
- Reset values: pc=RESET_PC, imem_addr=RESET_PC>>2, buffer empty, inst_valid=0, inst_data=0, inst_pc=0, fault=0, fault_pc=0, inflight=0, epoch=0, state=RUN.
- States: RUN, FAULT. Exit from FAULT is by rst only.
- RUN, issue rule: issue in cycle t iff `count + inflight - pop < 2`, where pop = inst_valid && inst_ready, and there is no redirect in t. On issue, inflight<=1, req_pc<=pc, req_epoch<=epoch, pc<=pc+4. pc wraps mod 2^32, so 32'hFFFF_FFFC is followed by 0.
- imem_addr always reflects the current pc. Memory reads in non-issue cycles are ignored because inflight=0.
- Capture: in the cycle after an issue, {req_pc, imem_rdata} is pushed into the buffer iff req_epoch==epoch. The credit rule guarantees the buffer never overflows.
- inst_valid = (count!=0) && !redirect_valid && state==RUN. inst_data/inst_pc always show the buffer head, and hold stable while valid && !ready.
- Redirect in RUN with redirect_pc[1:0]==0:
  - pc<=redirect_pc.
  - Buffer flushed.
  - epoch toggles, so any in-flight read is dropped.
  - No issue and no pop that cycle.
  - Simultaneous push, pop or issue is suppressed.
- Redirect with redirect_pc[1:0]!=0: state<=FAULT, fault<=1, fault_pc<=redirect_pc, buffer flushed.
- FAULT: no issue, inst_valid=0, further redirects ignored, fault_pc frozen.
- rst overrides everything, including a mid-flight read or redirect. Memory data arriving in the cycle after rst is dropped (inflight=0).

## Timing
- Issue at cycle t. Data is visible on imem_rdata in t+1, captured at the end of t+1, and inst_valid is high in t+2. Fetch-to-decode latency is 2 cycles.
- First inst_valid after rst deasserts: the third cycle (issue in cycle 1 after reset, valid in cycle 3).
- Redirect at t: first target issue at t+1, inst_valid with inst_pc=redirect_pc at t+3. Penalty: 3 bubbles.
- Steady state with inst_ready=1: one instruction per cycle, pc advancing +4 per cycle.
- inst_ready low for N cycles: the buffer fills to 2 and issue stops. After ready returns, there are no bubbles and no duplicates or drops.
- Fault raised the cycle after the misaligned redirect. inst_valid is 0 in the redirect cycle and in all later cycles.

## Structure
- Package mips_fetch_pkg holds:
  - state enum {RUN, FAULT}
  - WORD_SHIFT=2
  - INST_NOP=32'h0
  - BUF_DEPTH=2
- Sub-module fetch_skid_fifo holds the 2-entry {pc, inst} FIFO with push, pop, flush and count. Flush has priority over push and pop.
- The top level holds pc, the inflight/epoch tracking, the credit rule and the FSM.

## Test plan
- Reset then ready=1, memory word i = 32'h1000_0000+i: inst_valid first in cycle 3, then inst_pc 0,4,8,… with inst_data 32'h1000_0000, 32'h1000_0001, … every cycle.
- Hold inst_ready=0 for 5 cycles mid-stream: count saturates at 2, imem_addr stops advancing, and outputs stay stable. On release the sequence continues with no gap, duplicate or skip.
- Redirect to 32'h0000_0040 while one read is in flight and the buffer holds 2: old entries are never presented. The next valid has inst_pc=0x40 exactly 3 cycles later.
- Redirect to 32'h0000_0042: fault=1 and fault_pc=0x42 the next cycle, inst_valid stays 0. A later redirect to 0x10 has no effect until rst.
- rst asserted in the cycle a read is in flight: after release, the first inst_pc is RESET_PC and the stale data is never emitted.
- RESET_PC=32'hFFFF_FFF8: inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
